// File: rtl/hex_to_num_decoder_if.sv
// Decoded-digit output stream: num is held while num_valid waits for num_ready.
interface hex_to_num_decoder_if;
  logic [3:0] num;
  logic       num_valid;
  logic       num_ready;

  modport master (
    output num,
    output num_valid,
    input  num_ready
  );

  modport slave (
    input  num,
    input  num_valid,
    output num_ready
  );
endinterface

// File: rtl/hex_to_num_decoder.sv
// Synchronizes and debounces an active-low 7-segment pattern, decodes it to a digit
// and offers the result on a valid/ready stream, flagging illegal patterns and drops.
module hex_to_num_decoder #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [6:0]              HEX,
  hex_to_num_decoder_if.master    bus,
  output logic                    err,
  output logic                    overrun
);

  localparam logic [7:0] StableMax = 8'(STABLE_CYCLES);
  localparam logic [6:0] Blank     = 7'h7F;

  typedef enum logic [1:0] {StIdle, StSettling, StLocked} state_e;

  state_e     state_q;
  logic [6:0] s1_q, s2_q, last_q;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] digit;
  logic       legal, blank, stable, lock;

  always_comb begin
    legal = 1'b1;
    digit = 4'd0;
    case (s2_q)
      7'b1000000: digit = 4'd0;
      7'b1111001: digit = 4'd1;
      7'b0100100: digit = 4'd2;
      7'b0110000: digit = 4'd3;
      7'b0011001: digit = 4'd4;
      7'b0010010: digit = 4'd5;
      7'b0000010: digit = 4'd6;
      7'b1111000: digit = 4'd7;
      7'b0000000: digit = 4'd8;
      7'b0010000: digit = 4'd9;
      default:    legal = 1'b0;
    endcase
    blank  = (s2_q == Blank);
    stable = (cnt_q == StableMax);
    lock   = stable && (s2_q != last_q);
    // cnt counts cycles s2 has held its value, including the current one.
    if (s1_q != s2_q) begin
      cnt_d = 8'd1;
    end else if (stable) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q          <= Blank;
      s2_q          <= Blank;
      cnt_q         <= 8'd0;
      state_q       <= StIdle;
      last_q        <= Blank;
      bus.num       <= 4'd0;
      bus.num_valid <= 1'b0;
      err           <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      s1_q    <= HEX;
      s2_q    <= s1_q;
      cnt_q   <= cnt_d;
      err     <= 1'b0;
      overrun <= 1'b0;

      if (lock) begin
        state_q <= StLocked;
        last_q  <= s2_q;
      end else begin
        case (state_q)
          StIdle:     if (s2_q != last_q) state_q <= StSettling;
          StSettling: if (stable)         state_q <= StIdle;
          StLocked:   if (s2_q != last_q) state_q <= StSettling;
          default:                        state_q <= StIdle;
        endcase
      end

      if (lock && legal) begin
        if (!bus.num_valid || bus.num_ready) begin
          bus.num       <= digit;
          bus.num_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (bus.num_valid && bus.num_ready) begin
        bus.num_valid <= 1'b0;
      end

      if (lock && !legal && !blank) err <= 1'b1;
    end
  end

endmodule
